// File: rtl/piece_stager_if.sv
// piece_stager_if: bundle between the game controller, piece_stager and grid memory port A.
//   start/mode/piece/rot/color : operation request (controller -> stager)
//   busy/placed/err            : operation status (stager -> controller)
//   we/addr/data               : grid memory write port A (stager -> memory)
//   blk_addr0..3               : piece cell addresses, ascending (stager -> move/collision logic)
interface piece_stager_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
) ();
   logic              start;
   logic              mode;
   logic [2:0]        piece;
   logic [1:0]        rot;
   logic [DATA_W-1:0] color;
   logic              busy;
   logic              placed;
   logic              err;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic [ADDR_W-1:0] blk_addr0;
   logic [ADDR_W-1:0] blk_addr1;
   logic [ADDR_W-1:0] blk_addr2;
   logic [ADDR_W-1:0] blk_addr3;

   modport master (
      output start, mode, piece, rot, color,
      input  busy, placed, err, we, addr, data,
      input  blk_addr0, blk_addr1, blk_addr2, blk_addr3
   );

   modport slave (
      input  start, mode, piece, rot, color,
      output busy, placed, err, we, addr, data,
      output blk_addr0, blk_addr1, blk_addr2, blk_addr3
   );
endinterface

// File: rtl/piece_stager.sv
// piece_stager: stages a tetromino into a 4x4 window of grid memory.
// On an accepted start it latches mode/piece/rot/color, computes the piece's occupancy mask and
// its four cell addresses (sorted ascending), then either draws the whole window (PLACE) or
// zeroes only the four piece cells (ERASE) through grid memory port A.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : piece_stager_if.slave (request, status, write port A, cell addresses)
module piece_stager #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned BASE   = 232,
   parameter int unsigned STRIDE = 4
) (
   input  logic          clk,
   input  logic          rst,
   piece_stager_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StCalc, StWrite, StDone} state_e;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [3:0][ADDR_W-1:0] addr4_t;

   localparam logic [2:0] PieceIllegal = 3'd7;

   // Window cell address; int arithmetic truncated to ADDR_W gives the mod 2^ADDR_W wrap.
   function automatic addr_t cell_addr(input logic [1:0] r, input logic [1:0] c);
      return addr_t'(BASE + 32'(r) * STRIDE + 32'(c));
   endfunction

   // One clockwise quarter turn of a 4x4 mask (bit r*4+c): (r,c) -> (c, 3-r).
   function automatic logic [15:0] rot_cw(input logic [15:0] m);
      logic [15:0] o;
      o = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            o[c * 4 + (3 - r)] = m[r * 4 + c];
         end
      end
      return o;
   endfunction

   // Ascending sort of the four cell addresses; needed because wrap can break raster order.
   function automatic addr4_t sort4(input addr4_t a);
      addr4_t s;
      addr_t  tmp;
      s = a;
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 3 - p; i++) begin
            if (s[i] > s[i+1]) begin
               tmp    = s[i];
               s[i]   = s[i+1];
               s[i+1] = tmp;
            end
         end
      end
      return s;
   endfunction

   state_e            state_q, state_d;
   logic              mode_q, mode_d;
   logic [2:0]        piece_q, piece_d;
   logic [1:0]        rot_q, rot_d;
   logic [DATA_W-1:0] color_q, color_d;
   logic [15:0]       mask_q, mask_d;
   addr4_t            blk_q, blk_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              placed_q, placed_d;
   logic              err_q, err_d;
   logic              we_q, we_d;
   addr_t             addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;

   logic [15:0]       base_mask;
   logic [15:0]       mask_calc;
   addr4_t            cell_list;
   logic [2:0]        n_cells;

   // Occupancy mask and unsorted cell addresses from the latched piece/rotation.
   always_comb begin
      base_mask = '0;
      case (piece_q)
         3'd0:    base_mask = 16'h00F0;  // I
         3'd1:    base_mask = 16'h0066;  // O
         3'd2:    base_mask = 16'h0072;  // T
         3'd3:    base_mask = 16'h0036;  // S
         3'd4:    base_mask = 16'h0063;  // Z
         3'd5:    base_mask = 16'h0071;  // J
         3'd6:    base_mask = 16'h0074;  // L
         default: base_mask = '0;
      endcase

      unique case (rot_q)
         2'd0:    mask_calc = base_mask;
         2'd1:    mask_calc = rot_cw(base_mask);
         2'd2:    mask_calc = rot_cw(rot_cw(base_mask));
         default: mask_calc = rot_cw(rot_cw(rot_cw(base_mask)));
      endcase

      cell_list = '0;
      n_cells   = '0;
      for (int i = 0; i < 16; i++) begin
         if (mask_calc[i]) begin
            cell_list[n_cells[1:0]] = cell_addr(2'(i >> 2), 2'(i & 3));
            n_cells = n_cells + 3'd1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      piece_d  = piece_q;
      rot_d    = rot_q;
      color_d  = color_q;
      mask_d   = mask_q;
      blk_d    = blk_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      placed_d = placed_q;
      err_d    = err_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               mode_d   = bus.mode;
               piece_d  = bus.piece;
               rot_d    = bus.rot;
               color_d  = bus.color;
               busy_d   = 1'b1;
               placed_d = 1'b0;
               err_d    = 1'b0;
               state_d  = StCalc;
            end
         end
         StCalc: begin
            cnt_d = '0;
            // Illegal piece skips WRITE; DONE then reports err instead of placed.
            if (piece_q == PieceIllegal) begin
               state_d = StDone;
            end else begin
               mask_d  = mask_calc;
               blk_d   = sort4(cell_list);
               state_d = StWrite;
            end
         end
         StWrite: begin
            we_d = 1'b1;
            if (mode_q) begin
               addr_d = blk_q[cnt_q[1:0]];
               data_d = '0;
            end else begin
               addr_d = cell_addr(cnt_q[3:2], cnt_q[1:0]);
               data_d = mask_q[cnt_q] ? color_q : '0;
            end
            cnt_d = cnt_q + 4'd1;
            if ((mode_q && cnt_q == 4'd3) || cnt_q == 4'd15) begin
               state_d = StDone;
            end
         end
         StDone: begin
            busy_d   = 1'b0;
            placed_d = (piece_q != PieceIllegal);
            err_d    = (piece_q == PieceIllegal);
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StIdle;
         mode_q   <= 1'b0;
         piece_q  <= '0;
         rot_q    <= '0;
         color_q  <= '0;
         mask_q   <= '0;
         blk_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         placed_q <= 1'b0;
         err_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         piece_q  <= piece_d;
         rot_q    <= rot_d;
         color_q  <= color_d;
         mask_q   <= mask_d;
         blk_q    <= blk_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         placed_q <= placed_d;
         err_q    <= err_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.placed    = placed_q;
   assign bus.err       = err_q;
   assign bus.we        = we_q;
   assign bus.addr      = addr_q;
   assign bus.data      = data_q;
   assign bus.blk_addr0 = blk_q[0];
   assign bus.blk_addr1 = blk_q[1];
   assign bus.blk_addr2 = blk_q[2];
   assign bus.blk_addr3 = blk_q[3];

endmodule

// File: tb/tb_piece_stager.sv
// tb_piece_stager: directed and randomized stimulus for piece_stager, checked every cycle
// against a coordinate-level model of the operation plus hand-computed literal expectations.
module tb_piece_stager;

   localparam int BASE   = 232;
   localparam int STRIDE = 4;
   // Rotation-0 cells per piece, encoded row*10+col.
   localparam int SHAPES [7][4] = '{
      '{10, 11, 12, 13},  // I
      '{ 1,  2, 11, 12},  // O
      '{ 1, 10, 11, 12},  // T
      '{ 1,  2, 10, 11},  // S
      '{ 0,  1, 11, 12},  // Z
      '{ 0, 10, 11, 12},  // J
      '{ 2, 10, 11, 12}   // L
   };

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic mem_clr = 1'b1;
   always #5 clk = ~clk;

   piece_stager_if #(.DATA_W(8), .ADDR_W(8)) bus ();

   piece_stager #(
      .DATA_W(8),
      .ADDR_W(8),
      .BASE  (BASE),
      .STRIDE(STRIDE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Grid memory behind port A, plus a tally of writes landing outside the window.
   logic [7:0] gmem [256];
   int         out_of_win = 0;
   initial forever begin
      @(posedge clk);
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) gmem[i] = 8'd0;
      end else if (bus.we === 1'b1) begin
         gmem[bus.addr] = bus.data;
         if (int'(bus.addr) < BASE || int'(bus.addr) > BASE + 3 * STRIDE + 3) out_of_win++;
      end
   end

   // Reference model: t = edges since the accepting edge of the current operation.
   int         has_op = 0;
   int         t = 0;
   int         cur_w = 0;
   int         cur_ill = 0;
   int         blk_cur [4];
   int         blk_prev [4];
   int         wa [16];
   int         wd [16];
   logic [7:0] exp_mem [256];
   bit         chk_en = 0;

   initial begin
      int r, c, nr, tmp, p, ro;
      int a [4];
      bit occ [4][4];
      for (int k = 0; k < 4; k++) begin
         blk_cur[k]  = 0;
         blk_prev[k] = 0;
      end
      forever begin
         @(posedge clk);
         chk_en = 1;
         if (mem_clr) for (int i = 0; i < 256; i++) exp_mem[i] = 8'd0;
         if (!rst) begin
            has_op = 0;
            t      = 0;
            for (int k = 0; k < 4; k++) begin
               blk_cur[k]  = 0;
               blk_prev[k] = 0;
            end
         end else begin
            if (has_op != 0) t++;
            if ((has_op == 0 || t >= cur_w + 3) && bus.start === 1'b1) begin
               p  = int'(bus.piece);
               ro = int'(bus.rot);
               for (int k = 0; k < 4; k++) blk_prev[k] = blk_cur[k];
               has_op  = 1;
               t       = 0;
               cur_ill = (p == 7);
               if (p == 7) begin
                  cur_w = 0;
               end else begin
                  for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) occ[i][j] = 0;
                  for (int k = 0; k < 4; k++) begin
                     r = SHAPES[p][k] / 10;
                     c = SHAPES[p][k] % 10;
                     for (int q = 0; q < ro; q++) begin
                        nr = c;
                        c  = 3 - r;
                        r  = nr;
                     end
                     occ[r][c] = 1;
                     a[k] = (BASE + r * STRIDE + c) % 256;
                  end
                  // Selection sort, smallest first.
                  for (int i = 0; i < 3; i++) begin
                     for (int j = i + 1; j < 4; j++) begin
                        if (a[j] < a[i]) begin
                           tmp  = a[i];
                           a[i] = a[j];
                           a[j] = tmp;
                        end
                     end
                  end
                  for (int k = 0; k < 4; k++) blk_cur[k] = a[k];
                  if (bus.mode == 1'b0) begin
                     cur_w = 16;
                     for (int i = 0; i < 16; i++) begin
                        wa[i] = (BASE + (i / 4) * STRIDE + (i % 4)) % 256;
                        wd[i] = occ[i / 4][i % 4] ? int'(bus.color) : 0;
                     end
                  end else begin
                     cur_w = 4;
                     for (int i = 0; i < 4; i++) begin
                        wa[i] = a[i];
                        wd[i] = 0;
                     end
                  end
               end
            end else if (has_op != 0 && cur_ill == 0 && t >= 2 && t <= cur_w + 1) begin
               exp_mem[wa[t-2]] = 8'(wd[t-2]);
            end
         end
      end
   end

   // Per-cycle compare of every output against the model, 2 time units after each edge.
   int total_we = 0;
   initial begin
      logic [7:0] ab [4];
      bit         e_we;
      forever begin
         @(posedge clk);
         #2;
         if (chk_en) begin
            if (bus.we === 1'b1) total_we++;
            ab[0] = bus.blk_addr0;
            ab[1] = bus.blk_addr1;
            ab[2] = bus.blk_addr2;
            ab[3] = bus.blk_addr3;
            for (int k = 0; k < 4; k++) begin
               check($sformatf("cyc_blk%0d", k), 32'(ab[k]),
                     (has_op != 0 && t == 0) ? blk_prev[k] : blk_cur[k]);
            end
            if (has_op == 0) begin
               check("cyc_busy_rst", 32'(bus.busy), 0);
               check("cyc_placed_rst", 32'(bus.placed), 0);
               check("cyc_err_rst", 32'(bus.err), 0);
               check("cyc_we_rst", 32'(bus.we), 0);
               check("cyc_addr_rst", 32'(bus.addr), 0);
               check("cyc_data_rst", 32'(bus.data), 0);
            end else begin
               e_we = (cur_ill == 0 && t >= 2 && t <= cur_w + 1);
               check("cyc_busy", 32'(bus.busy), 32'(t <= cur_w + 1));
               check("cyc_placed", 32'(bus.placed), 32'(cur_ill == 0 && t >= cur_w + 2));
               check("cyc_err", 32'(bus.err), 32'(cur_ill != 0 && t >= 2));
               check("cyc_we", 32'(bus.we), 32'(e_we));
               if (e_we) begin
                  check("cyc_addr", 32'(bus.addr), wa[t-2]);
                  check("cyc_data", 32'(bus.data), wd[t-2]);
               end
            end
         end
      end
   end

   // Issue one operation from idle; lat = cycles from accepting edge to placed/err (-1 on timeout).
   task automatic run_op(input logic m, input logic [2:0] p, input logic [1:0] r,
                         input logic [7:0] col, input bit poke, output int lat, output int nwe);
      int we0;
      bus.mode  = m;
      bus.piece = p;
      bus.rot   = r;
      bus.color = col;
      bus.start = 1'b1;
      we0 = total_we;
      lat = -1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.mode  = 1'($urandom);
      bus.piece = 3'($urandom);
      bus.rot   = 2'($urandom);
      bus.color = 8'($urandom);
      for (int j = 0; j < 40; j++) begin
         if (bus.placed === 1'b1 || bus.err === 1'b1) begin
            lat = j;
            break;
         end
         if (poke && j == 8) bus.start = 1'b1;
         if (poke && j == 9) bus.start = 1'b0;
         @(negedge clk);
      end
      bus.start = 1'b0;
      nwe = total_we - we0;
   endtask

   task automatic mem_compare(input string name, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) check($sformatf("%s[%0d]", name, i), 32'(gmem[i]), 32'(exp_mem[i]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, nwe, we0, exp_lat, exp_nwe;
      logic       m;
      logic [2:0] p;
      logic [1:0] r;
      bus.start = 1'b0;
      bus.mode  = 1'b0;
      bus.piece = 3'd0;
      bus.rot   = 2'd0;
      bus.color = 8'd0;
      repeat (3) @(negedge clk);
      mem_clr = 1'b0;
      rst     = 1'b1;

      check("reset_busy", 32'(bus.busy), 0);
      check("reset_placed", 32'(bus.placed), 0);
      check("reset_we", 32'(bus.we), 0);
      check("reset_blk0", 32'(bus.blk_addr0), 0);

      // T rot 0 PLACE color 5.
      run_op(1'b0, 3'd2, 2'd0, 8'd5, 1'b0, lat, nwe);
      check("t0_placed_lat", lat, 18);
      check("t0_we_count", nwe, 16);
      check("t0_blk0", 32'(bus.blk_addr0), 233);
      check("t0_blk1", 32'(bus.blk_addr1), 236);
      check("t0_blk2", 32'(bus.blk_addr2), 237);
      check("t0_blk3", 32'(bus.blk_addr3), 238);
      @(negedge clk);
      for (int i = 232; i <= 247; i++) begin
         check($sformatf("t0_win[%0d]", i), 32'(gmem[i]),
               (i == 233 || i == 236 || i == 237 || i == 238) ? 5 : 0);
      end

      // T rot 1 PLACE, then ERASE it.
      run_op(1'b0, 3'd2, 2'd1, 8'd7, 1'b0, lat, nwe);
      check("t1_blk0", 32'(bus.blk_addr0), 234);
      check("t1_blk1", 32'(bus.blk_addr1), 238);
      check("t1_blk2", 32'(bus.blk_addr2), 239);
      check("t1_blk3", 32'(bus.blk_addr3), 242);
      run_op(1'b1, 3'd2, 2'd1, 8'd9, 1'b0, lat, nwe);
      check("erase_lat", lat, 6);
      check("erase_we_count", nwe, 4);
      @(negedge clk);
      check("erase_234", 32'(gmem[234]), 0);
      check("erase_238", 32'(gmem[238]), 0);
      check("erase_239", 32'(gmem[239]), 0);
      check("erase_242", 32'(gmem[242]), 0);
      mem_compare("erase_win", 232, 248);

      // I rot 1.
      run_op(1'b0, 3'd0, 2'd1, 8'd3, 1'b0, lat, nwe);
      check("i1_blk0", 32'(bus.blk_addr0), 234);
      check("i1_blk1", 32'(bus.blk_addr1), 238);
      check("i1_blk2", 32'(bus.blk_addr2), 242);
      check("i1_blk3", 32'(bus.blk_addr3), 246);

      // Illegal piece, then a valid start clears err.
      run_op(1'b0, 3'd7, 2'd0, 8'd1, 1'b0, lat, nwe);
      check("ill_lat", lat, 2);
      check("ill_err", 32'(bus.err), 1);
      check("ill_placed", 32'(bus.placed), 0);
      check("ill_we_count", nwe, 0);
      run_op(1'b0, 3'd6, 2'd3, 8'd4, 1'b0, lat, nwe);
      check("after_ill_err", 32'(bus.err), 0);
      check("after_ill_placed", 32'(bus.placed), 1);

      // Second start mid-WRITE is ignored.
      run_op(1'b0, 3'd4, 2'd2, 8'd9, 1'b1, lat, nwe);
      check("poke_we_count", nwe, 16);
      check("poke_lat", lat, 18);

      // Start held high across several operations.
      bus.mode  = 1'b0;
      bus.piece = 3'd3;
      bus.rot   = 2'd1;
      bus.color = 8'd6;
      bus.start = 1'b1;
      we0 = total_we;
      repeat (45) @(negedge clk);
      bus.start = 1'b0;
      for (int j = 0; j < 40; j++) begin
         if (bus.busy === 1'b0) break;
         @(negedge clk);
      end
      check("held_drained", 32'(bus.busy), 0);
      check("held_we_count", total_we - we0, 48);

      // Reset after the 5th write of a PLACE.
      bus.mode  = 1'b0;
      bus.piece = 3'd1;
      bus.rot   = 2'd0;
      bus.color = 8'h3c;
      bus.start = 1'b1;
      we0 = total_we;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      for (int j = 0; j < 40; j++) begin
         if (total_we - we0 >= 5) break;
         @(negedge clk);
      end
      check("rstmid_writes", total_we - we0, 5);
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_we", 32'(bus.we), 0);
      check("rstmid_busy", 32'(bus.busy), 0);
      check("rstmid_addr", 32'(bus.addr), 0);
      check("rstmid_blk0", 32'(bus.blk_addr0), 0);
      rst = 1'b1;
      @(negedge clk);
      mem_compare("rstmid_win", 232, 248);

      // Randomized operations.
      for (int n = 0; n < 40; n++) begin
         m = 1'($urandom_range(0, 1));
         p = 3'($urandom_range(0, 7));
         r = 2'($urandom_range(0, 3));
         exp_lat = (p == 3'd7) ? 2 : (m ? 6 : 18);
         exp_nwe = (p == 3'd7) ? 0 : (m ? 4 : 16);
         run_op(m, p, r, 8'($urandom_range(1, 255)), ($urandom_range(0, 3) == 0), lat, nwe);
         check("rand_lat", lat, exp_lat);
         check("rand_we_count", nwe, exp_nwe);
      end

      repeat (3) @(negedge clk);
      mem_compare("final_mem", 0, 255);
      check("out_of_window_writes", out_of_win, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
